// File: rtl/alu_mc.sv
// Multi-cycle ALU on the shared operand bus: A/B operand registers, single-cycle
// arithmetic/logic/shift, iterative shift-add multiply and restoring divide.
module alu_mc #(
    parameter int WIDTH = 10,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             CLKb,
    input  logic             RST,
    input  logic [WIDTH-1:0] OP,
    input  logic [3:0]       FN,
    input  logic             Ain,
    input  logic             Gin,
    input  logic             Gout,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             DZ,
    output logic             BUSY,
    output logic             DONE
);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] FN_ADD = 4'b0010, FN_SUB = 4'b0011, FN_NEG = 4'b0100;
    localparam logic [3:0] FN_NOT = 4'b0101, FN_AND = 4'b0110, FN_OR  = 4'b0111;
    localparam logic [3:0] FN_XOR = 4'b1000, FN_LSL = 4'b1001, FN_LSR = 4'b1010;
    localparam logic [3:0] FN_ASR = 4'b1011, FN_MUL = 4'b1100, FN_DIV = 4'b1101;
    localparam logic [3:0] FN_REM = 4'b1110;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state_r, state_s;
    logic [SHW-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0] a_r, b_r, w_r, w_s, hi_r, hi_s, lo_r, lo_s, q_r, q_s;
    logic             z_r, z_s, n_r, n_s, c_r, c_s, v_r, v_s, dz_r, dz_s;
    logic             busy_r, busy_s, done_r, done_s, rem_r, rem_s;

    logic [WIDTH:0]   add_s, mul_sum_s, div_sh_s;
    logic [WIDTH-1:0] sub_s, neg_s, asr_s, div_diff_s, alu_q_s;
    logic             shift_big_s, alu_c_s, alu_v_s, alu_dz_s, div_ge_s;

    // Single-cycle result, carry and overflow for the function presented on FN
    always_comb begin
        add_s       = {1'b0, a_r} + {1'b0, b_r};
        sub_s       = a_r - b_r;
        neg_s       = {WIDTH{1'b0}} - b_r;
        asr_s       = $signed(a_r) >>> b_r;
        shift_big_s = (b_r >= W_VAL);
        alu_q_s     = '0;
        alu_c_s     = 1'b0;
        alu_v_s     = 1'b0;
        alu_dz_s    = 1'b0;
        case (FN)
            FN_ADD: begin
                alu_q_s = add_s[MSB:0];
                alu_c_s = add_s[WIDTH];
                alu_v_s = (a_r[MSB] == b_r[MSB]) && (add_s[MSB] != a_r[MSB]);
            end
            FN_SUB: begin
                alu_q_s = sub_s;
                alu_c_s = (a_r >= b_r);
                alu_v_s = (a_r[MSB] != b_r[MSB]) && (sub_s[MSB] != a_r[MSB]);
            end
            FN_NEG: begin
                alu_q_s = neg_s;
                alu_v_s = (b_r == MIN_NEG);
            end
            FN_NOT: alu_q_s = ~b_r;
            FN_AND: alu_q_s = a_r & b_r;
            FN_OR:  alu_q_s = a_r | b_r;
            FN_XOR: alu_q_s = a_r ^ b_r;
            FN_LSL: alu_q_s = shift_big_s ? {WIDTH{1'b0}} : (a_r << b_r);
            FN_LSR: alu_q_s = shift_big_s ? {WIDTH{1'b0}} : (a_r >> b_r);
            FN_ASR: alu_q_s = shift_big_s ? {WIDTH{a_r[MSB]}} : asr_s;
            // Only reached with B==0; nonzero divisors take the iterative path
            FN_DIV: begin
                alu_q_s  = {WIDTH{1'b1}};
                alu_dz_s = 1'b1;
            end
            FN_REM: begin
                alu_q_s  = a_r;
                alu_dz_s = 1'b1;
            end
            default: alu_q_s = '0;
        endcase
    end

    // One iteration step: hi/lo hold accumulator/multiplier or remainder/quotient
    always_comb begin
        mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, w_r} : {(WIDTH+1){1'b0}});
        div_sh_s   = {hi_r, lo_r[MSB]};
        div_ge_s   = (div_sh_s >= {1'b0, w_r});
        div_diff_s = div_sh_s[MSB:0] - w_r;
    end

    // FSM next state, working registers and result/flag update
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        w_s     = w_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        rem_s   = rem_r;
        q_s     = q_r;
        c_s     = c_r;
        v_s     = v_r;
        dz_s    = dz_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (Gout) begin
                    if (FN == FN_MUL) begin
                        state_s = MUL;
                        cnt_s   = SHW'(WIDTH);
                        hi_s    = '0;
                        lo_s    = b_r;
                        w_s     = a_r;
                        busy_s  = 1'b1;
                    end else if (((FN == FN_DIV) || (FN == FN_REM)) && (b_r != '0)) begin
                        state_s = DIV;
                        cnt_s   = SHW'(WIDTH);
                        hi_s    = '0;
                        lo_s    = a_r;
                        w_s     = b_r;
                        rem_s   = (FN == FN_REM);
                        busy_s  = 1'b1;
                    end else begin
                        q_s    = alu_q_s;
                        c_s    = alu_c_s;
                        v_s    = alu_v_s;
                        dz_s   = alu_dz_s;
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL: begin
                hi_s  = mul_sum_s[WIDTH:1];
                lo_s  = {mul_sum_s[0], lo_r[MSB:1]};
                cnt_s = cnt_r - SHW'(1);
                if (cnt_r == SHW'(1)) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    q_s     = lo_s;
                    c_s     = (hi_s != '0);
                    v_s     = 1'b0;
                    dz_s    = 1'b0;
                end else begin
                    state_s = MUL;
                end
            end
            DIV: begin
                hi_s  = div_ge_s ? div_diff_s : div_sh_s[MSB:0];
                lo_s  = {lo_r[MSB-1:0], div_ge_s};
                cnt_s = cnt_r - SHW'(1);
                if (cnt_r == SHW'(1)) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    q_s     = rem_r ? hi_s : lo_s;
                    c_s     = 1'b0;
                    v_s     = 1'b0;
                    dz_s    = 1'b0;
                end else begin
                    state_s = DIV;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
        // Z and N track Q only when a result is written; they hold otherwise
        if (done_s) begin
            z_s = (q_s == '0);
            n_s = q_s[MSB];
        end else begin
            z_s = z_r;
            n_s = n_r;
        end
    end

    // State, operand and output registers; all updates on the falling edge
    always_ff @(negedge CLKb or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            w_r     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            rem_r   <= 1'b0;
            q_r     <= '0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
            c_r     <= 1'b0;
            v_r     <= 1'b0;
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (Ain) a_r <= OP;
            if (Gin) b_r <= OP;
            w_r     <= w_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            rem_r   <= rem_s;
            q_r     <= q_s;
            z_r     <= z_s;
            n_r     <= n_s;
            c_r     <= c_s;
            v_r     <= v_s;
            dz_r    <= dz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign Q    = q_r;
    assign Z    = z_r;
    assign N    = n_r;
    assign C    = c_r;
    assign V    = v_r;
    assign DZ   = dz_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=10; flags are compared as
// the packed vector {Z,N,C,V,DZ,BUSY,DONE}.
module tb_alu_mc;
    localparam int WIDTH = 10;
    localparam logic [3:0] FN_ADD = 4'b0010, FN_SUB = 4'b0011, FN_NEG = 4'b0100;
    localparam logic [3:0] FN_XOR = 4'b1000, FN_LSL = 4'b1001, FN_LSR = 4'b1010;
    localparam logic [3:0] FN_ASR = 4'b1011, FN_MUL = 4'b1100, FN_DIV = 4'b1101;
    localparam logic [3:0] FN_REM = 4'b1110, FN_NOP = 4'b1111;

    logic             CLKb, RST, Ain, Gin, Gout;
    logic [WIDTH-1:0] OP, Q;
    logic [3:0]       FN;
    logic             Z, N, C, V, DZ, BUSY, DONE;
    logic [6:0]       flags_s;
    int               n_vec, n_err, cyc, bad;

    assign flags_s = {Z, N, C, V, DZ, BUSY, DONE};

    alu_mc #(.WIDTH(WIDTH)) dut (
        .CLKb(CLKb), .RST(RST), .OP(OP), .FN(FN), .Ain(Ain), .Gin(Gin),
        .Gout(Gout), .Q(Q), .Z(Z), .N(N), .C(C), .V(V), .DZ(DZ),
        .BUSY(BUSY), .DONE(DONE)
    );

    initial CLKb = 1'b1;
    always #5 CLKb = ~CLKb;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLKb);
        #1;
    endtask

    task automatic load_ab(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        OP = a; Ain = 1'b1; tick(); Ain = 1'b0;
        OP = b; Gin = 1'b1; tick(); Gin = 1'b0;
    endtask

    task automatic start(input logic [3:0] fn);
        FN = fn; Gout = 1'b1; tick(); Gout = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (DONE !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        RST = 1'b1; Ain = 1'b0; Gin = 1'b0; Gout = 1'b0; OP = '0; FN = '0;
        #2;
        check_vec("reset q", 32'(Q), 32'd0);
        check_vec("reset flags", 32'(flags_s), 32'h00);
        tick(); RST = 1'b0;

        load_ab(10'd1023, 10'd1); start(FN_ADD);
        check_vec("add wrap q", 32'(Q), 32'd0);
        check_vec("add wrap flags", 32'(flags_s), 32'b1010001);
        tick();
        check_vec("done falls", 32'(DONE), 32'd0);

        load_ab(10'd5, 10'd7); start(FN_SUB);
        check_vec("sub q", 32'(Q), 32'd1022);
        check_vec("sub flags", 32'(flags_s), 32'b0100001);

        load_ab(10'h1FF, 10'd1); start(FN_ADD);
        check_vec("add ovf flags", 32'(flags_s), 32'b0101001);
        load_ab(10'd0, 10'h200); start(FN_NEG);
        check_vec("neg min q", 32'(Q), 32'h200);
        check_vec("neg min flags", 32'(flags_s), 32'b0101001);

        load_ab(10'h200, 10'd3); start(FN_ASR);
        check_vec("asr 3", 32'(Q), 32'h3C0);
        load_ab(10'h200, 10'd12); start(FN_ASR);
        check_vec("asr big", 32'(Q), 32'h3FF);
        load_ab(10'h200, 10'd9); start(FN_LSR);
        check_vec("lsr 9", 32'(Q), 32'd1);
        load_ab(10'd1, 10'd10); start(FN_LSL);
        check_vec("lsl 10", 32'(Q), 32'd0);
        check_vec("lsl 10 flags", 32'(flags_s), 32'b1000001);

        // Multiply with a Gout and an A reload mid-operation, plus a Gout on the completion edge
        load_ab(10'd25, 10'd30); start(FN_MUL);
        check_vec("mul busy start", 32'({BUSY, DONE}), 32'b10);
        bad = 0;
        for (int i = 1; i < WIDTH; i++) begin
            if (i == 3) begin Gout = 1'b1; FN = FN_ADD; Ain = 1'b1; OP = 10'd0; end
            tick(); Gout = 1'b0; Ain = 1'b0;
            if (BUSY !== 1'b1 || DONE !== 1'b0) bad = 1;
        end
        check_vec("mul busy hold", bad, 0);
        Gout = 1'b1; FN = FN_ADD; tick(); Gout = 1'b0;
        check_vec("mul q", 32'(Q), 32'd750);
        check_vec("mul flags", 32'(flags_s), 32'b0100001);
        tick();
        check_vec("late gout ignored", 32'({DONE, Q}), 32'd750);

        load_ab(10'd100, 10'd20); start(FN_MUL); wait_done(cyc);
        check_vec("mul2 latency", cyc, WIDTH);
        check_vec("mul2 q", 32'(Q), 32'd976);
        check_vec("mul2 flags", 32'(flags_s), 32'b0110001);

        load_ab(10'd1000, 10'd7); start(FN_DIV); wait_done(cyc);
        check_vec("div latency", cyc, WIDTH);
        check_vec("div q", 32'(Q), 32'd142);
        check_vec("div flags", 32'(flags_s), 32'b0000001);
        tick(); start(FN_REM); wait_done(cyc);
        check_vec("rem q", 32'(Q), 32'd6);
        check_vec("rem flags", 32'(flags_s), 32'b0000001);

        load_ab(10'd1000, 10'd0); start(FN_DIV);
        check_vec("div0 q", 32'(Q), 32'd1023);
        check_vec("div0 flags", 32'(flags_s), 32'b0100101);
        start(FN_REM);
        check_vec("rem0 q", 32'(Q), 32'd1000);
        check_vec("rem0 flags", 32'(flags_s), 32'b0100101);
        load_ab(10'h0F0, 10'h0FF); start(FN_XOR);
        check_vec("xor clears dz", 32'({Q, flags_s}), {15'd0, 10'h00F, 7'b0000001});

        // Asynchronous reset in the middle of a multiply
        load_ab(10'd25, 10'd30); start(FN_MUL);
        tick(); tick(); tick();
        #2 RST = 1'b1;
        #1 check_vec("rst mid q", 32'(Q), 32'd0);
        check_vec("rst mid flags", 32'(flags_s), 32'h00);
        #1 RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE !== 1'b0) bad = 1;
        end
        check_vec("no done after abort", bad, 0);
        load_ab(10'd3, 10'd4); start(FN_ADD);
        check_vec("add after rst", 32'({Q, flags_s}), {15'd0, 10'd7, 7'b0000001});

        load_ab(10'd5, 10'd5); start(FN_NOP);
        check_vec("unused fn q", 32'(Q), 32'd0);
        check_vec("unused fn flags", 32'(flags_s), 32'b1000001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
